// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Data-RAM side of the CPU load/store interface with a
//               one-word-per-cycle clear sweep on reset or clr.
//               Optional parity storage/check: define DATA_MEM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              ld,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              par_err
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic                w_we;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_load;
    logic                w_hold_load;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_waddr     = addr;
        w_wdata     = wdata;
        w_load      = 1'b0;
        w_hold_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                // clr wins over a same-cycle access, which is dropped
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end else if (sel) begin
                    w_load = ld;
                    w_we   = ~ld;
                end
            end
            S_CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_wdata   = '0;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == C_LAST) begin
                    w_state_nxt = clr ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                w_hold_load = sel & ld;
                if (!clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == S_CLEAR);
    // A write coinciding with an asserted reset is discarded
    assign w_mem_we = w_we & ~reset;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (busy || w_hold_load) begin
            rdata <= '0;
        end else if (w_load) begin
            rdata <= r_mem[addr];
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_par[w_waddr] <= ^w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_err <= 1'b0;
        end else if (w_hold_load) begin
            par_err <= 1'b0;
        end else if (w_load) begin
            par_err <= (^r_mem[addr]) != r_par[addr];
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

`default_nettype wire
